// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared state encoding and defaults for the instruction fetch stage.
package inst_fetch_pkg;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, FAULT} state_t;
    localparam logic [31:0] DEF_NOP = 32'h00000013;
    localparam int DEF_TIMEOUT = 255;
endpackage

// File: rtl/inst_fetch_timer.sv
// fetch_timer: 16-bit saturating wait counter; hit marks the last allowed wait cycle.
module fetch_timer
    import inst_fetch_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);
    logic [15:0] cnt;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    // cnt lags the wait-cycle number by one, so hit fires during the TIMEOUT-th wait cycle
    assign hit = cnt >= 16'(TIMEOUT - 1);
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: fetches the word at the core's pc over a valid/ready memory port and stalls the core until it arrives.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int          TIMEOUT = DEF_TIMEOUT,
    parameter logic [31:0] NOP     = DEF_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        stall,
    output logic        fault,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err
);
    state_t      state;
    logic [31:0] pc_q, inst_q;
    logic        hit;

    fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk(clk),
        .rst(rst),
        .clr(state != WAIT),
        .en (state == WAIT),
        .hit(hit)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state  <= IDLE;
            pc_q   <= '0;
            inst_q <= '0;
        end else
            case (state)
                IDLE, DONE: begin
                    state <= REQ;
                    pc_q  <= pc;
                end
                REQ: if (mem_req_ready) state <= WAIT;
                WAIT:
                    if (mem_rsp_valid && !mem_rsp_err) begin
                        inst_q <= mem_rsp_data;
                        state  <= DONE;
                    end else if (mem_rsp_valid || hit) state <= FAULT;
                default: state <= FAULT;
            endcase

    // every output is a pure decode of state and registers
    assign inst_valid    = state == DONE;
    assign stall         = !inst_valid;
    assign fault         = state == FAULT;
    assign inst          = inst_valid ? inst_q : NOP;
    assign mem_req_valid = state == REQ;
    assign mem_req_addr  = pc_q << 2;
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed and randomized fetches against a transaction-level expectation of the fetch stage.
module tb_inst_fetch;
    localparam logic [31:0] NOP_W = 32'h00000013;

    logic        clk = 0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid, stall, fault, mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid, mem_rsp_err;
    logic [31:0] mem_rsp_data;
    int          n_cmp = 0, n_bad = 0;

    inst_fetch #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .pc(pc), .inst(inst), .inst_valid(inst_valid),
        .stall(stall), .fault(fault), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_inst"}, inst, NOP_W);
        chk({tag, "_valid"}, inst_valid, 0);
        chk({tag, "_stall"}, stall, 1);
        chk({tag, "_fault"}, fault, 0);
        chk({tag, "_reqv"}, mem_req_valid, 0);
        chk({tag, "_addr"}, mem_req_addr, 0);
    endtask

    // Called mid-cycle; returns just after the edge that should start the first request.
    task automatic do_reset(input logic [31:0] new_pc);
        #3 rst = 0;
        #1 chk_reset_vals("async_rst");
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_err = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("held_rst");
        pc = new_pc;
        rst = 1;
        chk("idle_no_req", mem_req_valid, 0);
        step();
    endtask

    // Starts with the request freshly valid; ends with the next request freshly valid.
    task automatic fetch(input logic [31:0] nxt, input int rdy_wait, input int rsp_wait,
                         input logic [31:0] data, input bit spur);
        logic [31:0] exp_addr;
        exp_addr = pc * 4;
        chk("req_valid", mem_req_valid, 1);
        chk("req_addr", mem_req_addr, exp_addr);
        chk("req_stall", stall, 1);
        chk("req_inst_nop", inst, NOP_W);
        for (int i = 0; i < rdy_wait; i++) begin
            mem_req_ready = 0;
            mem_rsp_valid = spur;
            mem_rsp_data = 32'hFFFFFFFF;
            step();
            chk("hold_valid", mem_req_valid, 1);
            chk("hold_addr", mem_req_addr, exp_addr);
            chk("hold_stall", stall, 1);
        end
        mem_rsp_valid = 0;
        mem_req_ready = 1;
        step();
        mem_req_ready = 0;
        for (int i = 0; i < rsp_wait; i++) begin
            chk("wait_reqv", mem_req_valid, 0);
            chk("wait_stall", stall, 1);
            chk("wait_fault", fault, 0);
            if (i == rsp_wait - 1) begin
                mem_rsp_valid = 1;
                mem_rsp_data = data;
            end
            step();
        end
        mem_rsp_valid = 0;
        mem_rsp_data = $urandom;
        chk("done_valid", inst_valid, 1);
        chk("done_inst", inst, data);
        chk("done_stall", stall, 0);
        chk("done_fault", fault, 0);
        pc = nxt;
        step();
        chk("once_valid", inst_valid, 0);
        chk("once_inst", inst, NOP_W);
        chk("once_stall", stall, 1);
    endtask

    task automatic dead_window(input string tag);
        for (int i = 0; i < 20; i++) begin
            mem_req_ready = 1;
            mem_rsp_valid = $urandom_range(0, 1);
            mem_rsp_data = $urandom;
            step();
            chk({tag, "_fault"}, fault, 1);
            chk({tag, "_reqv"}, mem_req_valid, 0);
            chk({tag, "_inst"}, inst, NOP_W);
            chk({tag, "_valid"}, inst_valid, 0);
        end
        mem_req_ready = 0;
        mem_rsp_valid = 0;
    endtask

    initial begin
        rst = 0; pc = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_err = 0; mem_rsp_data = 0;
        #1 chk_reset_vals("por");
        repeat (3) step();
        chk_reset_vals("por_held");
        rst = 1;
        mem_req_ready = 1;
        chk("first_idle", mem_req_valid, 0);
        step();
        fetch(5, 0, 1, 32'h00500093, 0);
        fetch(6, 4, 2, $urandom, 0);
        fetch(7, 3, 3, $urandom, 1);
        fetch(32'h4000_0010, 0, 8, $urandom, 0);
        for (int n = 0; n < 30; n++) begin
            logic [31:0] nxt;
            int rw;
            bit sp;
            nxt = ($urandom_range(0, 3) == 0) ? $urandom : pc + 1;
            sp = $urandom_range(0, 1);
            rw = sp ? $urandom_range(1, 3) : $urandom_range(0, 3);
            fetch(nxt, rw, $urandom_range(1, 8), $urandom, sp);
        end
        // reset in the middle of a wait, then a fresh fetch for the new pc
        mem_req_ready = 1;
        step();
        mem_req_ready = 0;
        step();
        do_reset(32'h0000_0123);
        fetch(32'h124, 1, 2, $urandom, 0);
        // timeout: no response for eight wait cycles
        mem_req_ready = 1;
        step();
        mem_req_ready = 0;
        for (int k = 1; k <= 8; k++) begin
            chk("to_pending", fault, 0);
            step();
        end
        chk("to_fault", fault, 1);
        chk("to_inst", inst, NOP_W);
        dead_window("to_dead");
        // error response
        do_reset(32'h0000_0040);
        fetch(32'h41, 0, 1, $urandom, 0);
        mem_req_ready = 1;
        step();
        mem_req_ready = 0;
        mem_rsp_valid = 1;
        mem_rsp_err = 1;
        mem_rsp_data = $urandom;
        step();
        mem_rsp_valid = 0;
        mem_rsp_err = 0;
        chk("err_fault", fault, 1);
        chk("err_inst", inst, NOP_W);
        chk("err_valid", inst_valid, 0);
        dead_window("err_dead");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
